alu_sequencer: RTL and testbench

//  Issue/response front end driving the 3-bit-command ALU: accepts MIPS R-type requests (funct + operands)
//  on valid/ready, decodes funct to ALU command, drives the external ALU, registers result + flags.

---
 rtl/alu_sequencer_pkg.sv | 41 ++++
 rtl/alu_funct_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue/response sequencer:
// ALU command codes, MIPS funct codes, FSM states, decode bundle.
package alu_sequencer_pkg;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    // Command recorded for unsupported functs; the ALU is never driven with it.
    localparam logic [2:0] CMD_ERR  = 3'b000;

    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] cmd;
        logic       is_mul;
        logic       is_err;
    } dec_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS R-type funct decoder:
// funct -> ALU command plus multiply / unsupported markers.
module alu_funct_decode
    import alu_sequencer_pkg::*;
(
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Map each supported funct to its ALU command; anything else is an error.
    always_comb begin
        dec = '{cmd: CMD_ERR, is_mul: 1'b0, is_err: 1'b0};
        case (funct)
            FN_ADD, FN_ADDU: dec.cmd = CMD_ADD;
            FN_SUB, FN_SUBU: dec.cmd = CMD_SUB;
            FN_AND:          dec.cmd = CMD_AND;
            FN_OR:           dec.cmd = CMD_OR;
            FN_XOR:          dec.cmd = CMD_XOR;
            FN_NOR:          dec.cmd = CMD_NOR;
            FN_SLT:          dec.cmd = CMD_SLT;
            FN_MULTU: begin
                dec.cmd    = CMD_ADD;
                dec.is_mul = 1'b1;
            end
            default:         dec.is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/response front end for the 3-bit-command ALU.
// Single-cycle ops go through EXEC; MULTU is shift-add over WIDTH ALU adds.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t           state;
    dec_t             dec;
    logic [2:0]       cmd_q;
    logic             err_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] prod_hi;
    logic [CW-1:0]    cnt;
    logic             add_en;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    alu_funct_decode u_dec (
        .funct (req_funct),
        .dec   (dec)
    );

    assign req_ready = (state == ST_IDLE);

    // In MUL, op_a is the multiplicand and op_b holds the low product word.
    assign add_en = op_b[0];

    // One shift-add step: {carry, sum-or-hi, lo} shifted right by one.
    always_comb begin
        if (add_en) begin
            nxt_hi = {alu_carryout, alu_result[WIDTH-1:1]};
            nxt_lo = {alu_result[0], op_b[WIDTH-1:1]};
        end else begin
            nxt_hi = {1'b0, prod_hi[WIDTH-1:1]};
            nxt_lo = {prod_hi[0], op_b[WIDTH-1:1]};
        end
    end

    // ALU inputs stay quiet except in EXEC and in MUL add cycles.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_command = CMD_ADD;
        if (state == ST_EXEC) begin
            alu_a       = op_a;
            alu_b       = op_b;
            alu_command = cmd_q;
        end else if (state == ST_MUL && add_en) begin
            alu_a       = prod_hi;
            alu_b       = op_a;
            alu_command = CMD_ADD;
        end
    end

    // Sequencer FSM with operand, product, counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_q        <= CMD_ADD;
            err_q        <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            prod_hi      <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_hi       <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_a    <= req_a;
                        op_b    <= req_b;
                        prod_hi <= '0;
                        cmd_q   <= dec.cmd;
                        if (dec.is_err) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (dec.is_mul) begin
                            cnt   <= CNT_INIT;
                            state <= ST_MUL;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_valid    <= 1'b1;
                    rsp_result   <= alu_result;
                    rsp_hi       <= '0;
                    rsp_carry    <= alu_carryout;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_err      <= 1'b0;
                    state        <= ST_RESP;
                end
                ST_MUL: begin
                    prod_hi <= nxt_hi;
                    op_b    <= nxt_lo;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        rsp_valid    <= 1'b1;
                        rsp_result   <= nxt_lo;
                        rsp_hi       <= nxt_hi;
                        rsp_carry    <= 1'b0;
                        rsp_zero     <= ({nxt_hi, nxt_lo} == '0);
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!rsp_valid) begin
                        // Unsupported funct: response one cycle after accept.
                        rsp_valid    <= 1'b1;
                        rsp_err      <= err_q;
                        rsp_result   <= '0;
                        rsp_hi       <= '0;
                        rsp_carry    <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_overflow <= 1'b0;
                    end else if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        rsp_err      <= 1'b0;
                        rsp_result   <= '0;
                        rsp_hi       <= '0;
                        rsp_carry    <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_overflow <= 1'b0;
                        err_q        <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 32-bit ALU
// on the alu_* ports; table vectors feed a scoreboard queue.
module tb_alu_sequencer;

    localparam int W = 32;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         v;
        logic         err;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_funct;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [W-1:0] rsp_hi;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_overflow;
    logic         rsp_err;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_command;
    logic [W-1:0] alu_result;
    logic         alu_carryout;
    logic         alu_zero;
    logic         alu_overflow;

    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct    (req_funct),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_hi       (rsp_hi),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    // Behavioural ALU; flags only meaningful for ADD/SUB.
    always_comb begin
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            3'b000: begin
                {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) &&
                               (alu_result[W-1] != alu_a[W-1]);
                alu_zero = (alu_result == '0);
            end
            3'b001: begin
                {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) &&
                               (alu_result[W-1] != alu_a[W-1]);
                alu_zero = (alu_result == '0);
            end
            3'b010: alu_result = alu_a ^ alu_b;
            3'b011: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = ~(alu_a & alu_b);
            3'b110: alu_result = ~(alu_a | alu_b);
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int   cyc;
        vec_t e;
        @(negedge clk);
        chk("req_ready_before_issue", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_funct = v.funct;
        req_a     = v.a;
        req_b     = v.b;
        sb.push_back(v);
        n_vec++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!rsp_valid) begin
            n_bad++;
            $display("FAIL rsp_timeout: funct %h no response in %0d cycles", v.funct, cyc);
        end
        @(negedge clk);
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: response with nothing expected");
        end else begin
            e = sb.pop_front();
            chk($sformatf("latency_%h", e.funct), 64'(cyc), 64'(e.lat));
            chk($sformatf("result_%h", e.funct), 64'(rsp_result), 64'(e.res));
            chk($sformatf("hi_%h", e.funct), 64'(rsp_hi), 64'(e.hi));
            chk($sformatf("flags_%h", e.funct),
                64'({rsp_carry, rsp_zero, rsp_overflow, rsp_err}),
                64'({e.c, e.z, e.v, e.err}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
        chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    initial begin
        vec_t bp;
        int   cyc;

        tbl[0]  = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[1]  = '{6'h22, 32'h12345678, 32'h12345678, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32};
        tbl[4]  = '{6'h08, 32'h11111111, 32'h22222222, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[5]  = '{6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{6'h26, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{6'h21, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[10] = '{6'h23, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{6'h19, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32};
        tbl[12] = '{6'h19, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32};
        tbl[13] = '{6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[14] = '{6'h3F, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_funct = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp", 64'({rsp_result, rsp_hi} | 64'({rsp_carry, rsp_zero, rsp_overflow, rsp_err})), 64'd0);
        chk("reset_alu", 64'({alu_a, alu_b} | 64'(alu_command)), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run(tbl[i]);

        // Unsupported funct keeps the ALU quiet and blocks new requests.
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = 6'h08;
        req_a     = 32'hDEADBEEF;
        req_b     = 32'h12345678;
        n_vec++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("err_alu_quiet", 64'({alu_a, alu_b} | 64'(alu_command)), 64'd0);
        chk("err_req_ready_low", 64'(req_ready), 64'd0);
        chk("err_not_yet_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("err_rsp_held", 64'({rsp_valid, rsp_err}), 64'b11);
            chk("err_req_ready_held", 64'(req_ready), 64'd0);
            chk("err_alu_held_quiet", 64'({alu_a, alu_b} | 64'(alu_command)), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("err_released", 64'({rsp_valid, req_ready}), 64'b01);

        // Backpressure: response held, competing request ignored.
        bp = '{6'h20, 32'd5, 32'd6, 32'd11, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = bp.funct;
        req_a     = bp.a;
        req_b     = bp.b;
        n_vec++;
        @(posedge clk);
        #1;
        req_funct = 6'h25;
        req_a     = 32'hFFFF0000;
        req_b     = 32'h0000FFFF;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp_latency", 64'(cyc), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(rsp_valid), 64'd1);
            chk("bp_result_held", 64'(rsp_result), 64'(bp.res));
            chk("bp_flags_held", 64'({rsp_carry, rsp_zero, rsp_overflow, rsp_err}), 64'd0);
            chk("bp_req_ready_low", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_capture", 64'({rsp_valid, req_ready}), 64'b01);
        end

        // Reset during MUL iteration 10 discards the multiply.
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = 6'h19;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
        n_vec++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mul_busy", 64'({req_ready, rsp_valid}), 64'd0);
        chk("mul_alu_active", 64'(alu_b), 64'hFFFFFFFF);
        reset = 1'b1;
        #1;
        chk("rst_mid_mul_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_mul_rsp", 64'({rsp_valid, rsp_err, rsp_carry, rsp_zero, rsp_overflow}), 64'd0);
        chk("rst_mid_mul_data", 64'({rsp_result, rsp_hi}), 64'd0);
        chk("rst_mid_mul_alu", 64'({alu_a, alu_b} | 64'(alu_command)), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("rst_no_stale_rsp", 64'({rsp_valid, req_ready}), 64'b01);
        run('{6'h19, 32'd3, 32'd5, 32'd15, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32});

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
